// File: rtl/audio_clk_nco_if.sv
// Rate select and clock outputs shared between the audio clock generator and its consumers.
// The master drives rate_sel; the slave (the generator) drives the clock levels, strobes and lock.
interface audio_clk_nco_if;
    logic [1:0] rate_sel;
    logic       mclk;
    logic       sclk;
    logic       lrclk;
    logic       mclk_fall;
    logic       sclk_fall;
    logic       frame_start;
    logic       locked;

    modport master (
        output rate_sel,
        input  mclk, sclk, lrclk, mclk_fall, sclk_fall, frame_start, locked
    );

    modport slave (
        input  rate_sel,
        output mclk, sclk, lrclk, mclk_fall, sclk_fall, frame_start, locked
    );
endinterface

// File: rtl/audio_clk_nco.sv
// PLL-free audio clock generator: a fractional phase accumulator on refclk produces
// MCLK/SCLK/LRCLK levels and fall strobes, with a restart/relock sequence on rate change.
module audio_clk_nco #(
    parameter int unsigned REF_HZ      = 74250000,
    parameter int unsigned ACC_W       = 32,
    parameter int unsigned FRAME_LOG2  = 8,
    parameter int unsigned SCLK_LOG2   = 2,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic           refclk,
    input  logic           rst_n,
    audio_clk_nco_if.slave bus
);

    function automatic logic [63:0] calc_inc(input logic [63:0] fs_hz);
        logic [63:0] num;
        num = 64'd2 * (64'd1 << FRAME_LOG2) * fs_hz * (64'd1 << ACC_W);
        return (num + 64'(REF_HZ / 2)) / 64'(REF_HZ);
    endfunction

    localparam logic [63:0] INC48_W  = calc_inc(64'd48000);
    localparam logic [63:0] INC441_W = calc_inc(64'd44100);
    localparam logic [63:0] INC32_W  = calc_inc(64'd32000);
    localparam logic [63:0] INC_LIM  = 64'd1 << (ACC_W - 1);

    // A half MCLK period must span at least two refclk cycles.
    if (INC48_W >= INC_LIM || INC441_W >= INC_LIM || INC32_W >= INC_LIM) begin : g_inc_check
        $error("audio_clk_nco: MCLK too fast for REF_HZ");
    end

    localparam logic [ACC_W-1:0] INC_48  = INC48_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC_441 = INC441_W[ACC_W-1:0];
    localparam logic [ACC_W-1:0] INC_32  = INC32_W[ACC_W-1:0];
    localparam int unsigned      LCW     = $clog2(LOCK_FRAMES + 1);

    typedef enum logic {ST_RUN, ST_RESTART} state_e;

    state_e                state_q, state_d;
    logic [1:0]            cur_rate_q, cur_rate_d;
    logic                  chg_q, chg_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [FRAME_LOG2-1:0] div_q, div_d;
    logic                  mclk_q, mclk_d;
    logic                  sclk_q, sclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  mclk_fall_q, mclk_fall_d;
    logic                  sclk_fall_q, sclk_fall_d;
    logic                  frame_start_q, frame_start_d;
    logic [LCW-1:0]        lock_cnt_q, lock_cnt_d;
    logic                  locked_q, locked_d;

    logic [ACC_W-1:0]      inc;
    logic [ACC_W:0]        sum;
    logic                  tick;
    logic                  restart;

    always_comb begin
        state_d       = state_q;
        cur_rate_d    = cur_rate_q;
        acc_d         = acc_q;
        div_d         = div_q;
        mclk_d        = mclk_q;
        sclk_d        = sclk_q;
        lrclk_d       = lrclk_q;
        mclk_fall_d   = 1'b0;
        sclk_fall_d   = 1'b0;
        frame_start_d = 1'b0;
        lock_cnt_d    = lock_cnt_q;
        locked_d      = locked_q;

        // Code 3 is reserved and runs at 48 kHz.
        case (cur_rate_q)
            2'd1:    inc = INC_441;
            2'd2:    inc = INC_32;
            default: inc = INC_48;
        endcase
        sum     = {1'b0, acc_q} + {1'b0, inc};
        tick    = sum[ACC_W];
        restart = (state_q == ST_RUN) && chg_q;

        if (restart || state_q == ST_RESTART) begin
            state_d    = restart ? ST_RESTART : ST_RUN;
            acc_d      = '0;
            div_d      = '0;
            mclk_d     = 1'b0;
            sclk_d     = 1'b0;
            lrclk_d    = 1'b0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            if (restart) cur_rate_d = bus.rate_sel;
        end else begin
            acc_d       = sum[ACC_W-1:0];
            mclk_d      = mclk_q ^ tick;
            mclk_fall_d = tick & mclk_q;
            if (mclk_fall_d) div_d = div_q + FRAME_LOG2'(1);
            sclk_d        = div_d[SCLK_LOG2-1];
            lrclk_d       = div_d[FRAME_LOG2-1];
            sclk_fall_d   = sclk_q & ~sclk_d;
            frame_start_d = lrclk_q & ~lrclk_d;
            if (!locked_q && frame_start_q) lock_cnt_d = lock_cnt_q + LCW'(1);
            locked_d = locked_q | (lock_cnt_d == LCW'(LOCK_FRAMES));
        end

        // Compare against the rate that will be in effect, so the restart cycle itself
        // does not re-trigger; a further change during RESTART is still caught.
        chg_d = (bus.rate_sel != cur_rate_d);
    end

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            cur_rate_q    <= bus.rate_sel;
            chg_q         <= 1'b0;
            acc_q         <= '0;
            div_q         <= '0;
            mclk_q        <= 1'b0;
            sclk_q        <= 1'b0;
            lrclk_q       <= 1'b0;
            mclk_fall_q   <= 1'b0;
            sclk_fall_q   <= 1'b0;
            frame_start_q <= 1'b0;
            lock_cnt_q    <= '0;
            locked_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_rate_q    <= cur_rate_d;
            chg_q         <= chg_d;
            acc_q         <= acc_d;
            div_q         <= div_d;
            mclk_q        <= mclk_d;
            sclk_q        <= sclk_d;
            lrclk_q       <= lrclk_d;
            mclk_fall_q   <= mclk_fall_d;
            sclk_fall_q   <= sclk_fall_d;
            frame_start_q <= frame_start_d;
            lock_cnt_q    <= lock_cnt_d;
            locked_q      <= locked_d;
        end
    end

    assign bus.mclk        = mclk_q;
    assign bus.sclk        = sclk_q;
    assign bus.lrclk       = lrclk_q;
    assign bus.mclk_fall   = mclk_fall_q;
    assign bus.sclk_fall   = sclk_fall_q;
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = locked_q;

endmodule

// File: tb/tb_audio_clk_nco.sv
// Bench for audio_clk_nco: per-cycle comparison against an arithmetic tick-count model,
// plus frame timing, lock timing, restart and reset scenarios.
module tb_audio_clk_nco;
    localparam int unsigned REF_HZ = 74250000;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned FL     = 8;
    localparam int unsigned SL     = 2;
    localparam int unsigned LOCK   = 2;
    localparam longint      FRAME_TICKS = 2 * (64'd1 << FL);

    logic refclk = 1'b0;
    logic rst_n  = 1'b0;
    audio_clk_nco_if bus();

    audio_clk_nco #(.REF_HZ(REF_HZ), .ACC_W(ACC_W), .FRAME_LOG2(FL),
                    .SCLK_LOG2(SL), .LOCK_FRAMES(LOCK)) dut (
        .refclk(refclk), .rst_n(rst_n), .bus(bus));

    always #5 refclk = ~refclk;

    longint cyc = 0;
    logic   rst_at_edge = 1'b1;
    always @(posedge refclk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= !rst_n;
    end

    int checks = 0, errors = 0, align_bad = 0;
    // Model: output state is a function of cycles since (re)start and the rate increment.
    longint            base = 0;
    longint unsigned   inc = 0;
    logic [1:0]        mrate = 2'd0;
    bit                sw_pend = 0;
    longint            sw_at = 0, sw_base = 0;
    longint unsigned   sw_inc = 0;
    logic [6:0]        obs, exp_v;   // {locked, frame_start, sclk_fall, mclk_fall, lrclk, sclk, mclk}
    logic [1:0]        prev_lvl = 2'b00;
    int                cnt_mf = 0, cnt_sf = 0, fs_mf = 0, fs_sf = 0;
    bit                fs_now = 0;

    function automatic longint unsigned fs_of(input logic [1:0] r);
        case (r)
            2'd1:    return 64'd44100;
            2'd2:    return 64'd32000;
            default: return 64'd48000;
        endcase
    endfunction

    function automatic longint unsigned inc_of(input logic [1:0] r);
        return (64'd2 * (64'd1 << FL) * fs_of(r) * (64'd1 << ACC_W) + 64'(REF_HZ / 2)) / 64'(REF_HZ);
    endfunction

    // Cycle (counted from the restart base) on which the k-th MCLK half-period ends.
    function automatic longint ceil_at(input longint k, input longint unsigned i);
        return longint'((64'(k) * (64'd1 << ACC_W) + i - 1) / i);
    endfunction

    function automatic logic [6:0] model(input longint m, input longint unsigned i);
        longint unsigned t, tp, f, fp, d;
        if (m <= 0) return 7'd0;
        t  = (64'(m) * i) >> ACC_W;
        tp = (64'(m - 1) * i) >> ACC_W;
        f  = t >> 1;
        fp = tp >> 1;
        d  = f % (64'd1 << FL);
        return {(fp >> FL) >= LOCK, (f >> FL) != (fp >> FL), (f >> SL) != (fp >> SL),
                f != fp, d[FL-1], d[SL-1], t[0]};
    endfunction

    task automatic step();
        @(negedge refclk);
        if (rst_at_edge) begin cnt_mf = 0; cnt_sf = 0; end
        if (sw_pend && cyc >= sw_at) begin
            base = sw_base; inc = sw_inc; sw_pend = 0; cnt_mf = 0; cnt_sf = 0;
        end
        obs   = {bus.locked, bus.frame_start, bus.sclk_fall, bus.mclk_fall,
                 bus.lrclk, bus.sclk, bus.mclk};
        exp_v = rst_at_edge ? 7'd0 : model(cyc - base, inc);
        if (obs[3]) cnt_mf++;
        if (obs[4]) cnt_sf++;
        fs_now = obs[5];
        if (fs_now) begin fs_mf = cnt_mf; fs_sf = cnt_sf; cnt_mf = 0; cnt_sf = 0; end
        if (!rst_at_edge && (cyc - base) > 0 && obs[2:1] != prev_lvl && !obs[3]) align_bad++;
        prev_lvl = obs[2:1];
    endtask

    // Called at a negedge right after step(); restart lands two edges later.
    task automatic set_rate(input logic [1:0] r);
        bus.rate_sel = r;
        if (r != mrate) begin
            sw_pend = 1; sw_at = cyc + 2; sw_base = cyc + 3; sw_inc = inc_of(r); mrate = r;
        end
    endtask

    task automatic test_reset();
        longint first_rise = -1, lock_cyc = -1;
        bus.rate_sel = 2'd0;
        rst_n = 1'b0;
        repeat (5) begin
            step(); checks++;
            if (obs !== 7'd0) begin errors++; $display("FAIL reset_state: got %b want 0000000", obs); end
        end
        rst_n = 1'b1; base = cyc; mrate = 2'd0; inc = inc_of(2'd0); sw_pend = 0;
        for (int i = 0; i < 4000 && lock_cyc < 0; i++) begin
            step(); checks++;
            if (obs !== exp_v) begin
                errors++; if (errors < 20) $display("FAIL reset_model cyc=%0d: got %b want %b", cyc, obs, exp_v);
            end
            if (obs[0] && first_rise < 0) first_rise = cyc;
            if (obs[6]) lock_cyc = cyc;
        end
        checks++;
        if (first_rise - base != ceil_at(1, inc) || first_rise - base < 2) begin
            errors++; $display("FAIL first_mclk_rise: got %0d want %0d", first_rise - base, ceil_at(1, inc));
        end
        checks++;
        if (lock_cyc - base != ceil_at(LOCK * FRAME_TICKS, inc) + 1) begin
            errors++; $display("FAIL reset_lock: got %0d want %0d", lock_cyc - base, ceil_at(LOCK * FRAME_TICKS, inc) + 1);
        end
    endtask

    task automatic test_rate(input logic [1:0] r);
        longint fsc[4];
        longint rb, nom, diff;
        longint unsigned ri;
        int nfs = 0;
        set_rate(r);
        rb = sw_base; ri = sw_inc;
        for (int i = 0; i < 12000 && nfs < 4; i++) begin
            step(); checks++;
            if (obs !== exp_v) begin
                errors++; if (errors < 20) $display("FAIL rate%0d_model cyc=%0d: got %b want %b", r, cyc, obs, exp_v);
            end
            if (fs_now) begin
                fsc[nfs] = cyc;
                checks++;
                if (cyc - rb != ceil_at((nfs + 1) * FRAME_TICKS, ri)) begin
                    errors++; $display("FAIL rate%0d_frame%0d: got %0d want %0d", r, nfs, cyc - rb, ceil_at((nfs + 1) * FRAME_TICKS, ri));
                end
                checks++;
                if (fs_mf != 256 || fs_sf != 64) begin
                    errors++; $display("FAIL rate%0d_counts: got mclk_fall=%0d sclk_fall=%0d want 256 64", r, fs_mf, fs_sf);
                end
                nfs++;
            end
        end
        checks++;
        if (nfs < 4) begin
            errors++; $display("FAIL rate%0d_timeout: got %0d frames want 4", r, nfs);
        end else begin
            nom  = longint'((64'd3 * REF_HZ + fs_of(r) / 2) / fs_of(r));
            diff = fsc[3] - fsc[0];
            if (diff > nom + 2 || diff < nom - 2) begin
                errors++; $display("FAIL rate%0d_period: got %0d want %0d+-2", r, diff, nom);
            end
        end
    endtask

    task automatic test_midframe();
        bit found = 0;
        longint first_fs = -1, lock_cyc = -1, rb;
        for (int i = 0; i < 3000 && !found; i++) begin
            step(); if (obs[2] && obs[6]) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL midframe_wait: got no locked lrclk=1 want one"); end
        set_rate(2'd1);
        rb = sw_base;
        step(); checks++;
        if (obs[6] !== 1'b1) begin errors++; $display("FAIL midframe_early: got locked=%b want 1", obs[6]); end
        step(); checks++;
        if (obs !== 7'd0) begin errors++; $display("FAIL midframe_clear: got %b want 0000000", obs); end
        for (int i = 0; i < 4000 && lock_cyc < 0; i++) begin
            step(); checks++;
            if (obs !== exp_v) begin
                errors++; if (errors < 20) $display("FAIL midframe_model cyc=%0d: got %b want %b", cyc, obs, exp_v);
            end
            if (fs_now && first_fs < 0) first_fs = cyc;
            if (obs[6]) lock_cyc = cyc;
        end
        checks++;
        if (first_fs - rb != ceil_at(FRAME_TICKS, inc)) begin
            errors++; $display("FAIL midframe_first_fs: got %0d want %0d", first_fs - rb, ceil_at(FRAME_TICKS, inc));
        end
        checks++;
        if (lock_cyc - rb != ceil_at(LOCK * FRAME_TICKS, inc) + 1) begin
            errors++; $display("FAIL midframe_lock: got %0d want %0d", lock_cyc - rb, ceil_at(LOCK * FRAME_TICKS, inc) + 1);
        end
    endtask

    task automatic test_restart_in_restart();
        longint lock_cyc = -1, rb;
        set_rate(2'd2);
        step(); step();
        set_rate(2'd0);
        rb = sw_base;
        for (int i = 0; i < 4000 && lock_cyc < 0; i++) begin
            step(); checks++;
            if (obs !== exp_v) begin
                errors++; if (errors < 20) $display("FAIL rr_model cyc=%0d: got %b want %b", cyc, obs, exp_v);
            end
            if (obs[6]) lock_cyc = cyc;
        end
        checks++;
        if (lock_cyc - rb != ceil_at(LOCK * FRAME_TICKS, inc_of(2'd0)) + 1) begin
            errors++; $display("FAIL rr_lock: got %0d want %0d", lock_cyc - rb, ceil_at(LOCK * FRAME_TICKS, inc_of(2'd0)) + 1);
        end
    endtask

    task automatic test_relock_change();
        bit seen = 0;
        longint lock_cyc = -1, rb;
        set_rate(2'd1);
        for (int i = 0; i < 2500 && !seen; i++) begin
            step(); checks++;
            if (obs !== exp_v) begin
                errors++; if (errors < 20) $display("FAIL relock_model cyc=%0d: got %b want %b", cyc, obs, exp_v);
            end
            if (fs_now) seen = 1;
        end
        set_rate(2'd2);
        rb = sw_base;
        for (int i = 0; i < 6000 && lock_cyc < 0; i++) begin
            step(); checks++;
            if (obs !== exp_v) begin
                errors++; if (errors < 20) $display("FAIL relock_model cyc=%0d: got %b want %b", cyc, obs, exp_v);
            end
            if (obs[6]) lock_cyc = cyc;
        end
        checks++;
        if (lock_cyc - rb != ceil_at(LOCK * FRAME_TICKS, inc_of(2'd2)) + 1) begin
            errors++; $display("FAIL relock_lock: got %0d want %0d", lock_cyc - rb, ceil_at(LOCK * FRAME_TICKS, inc_of(2'd2)) + 1);
        end
    endtask

    task automatic test_reset_midop();
        longint lock_cyc = -1;
        rst_n = 1'b0; bus.rate_sel = 2'd0;
        step(); checks++;
        if (obs !== 7'd0) begin errors++; $display("FAIL midop_reset: got %b want 0000000", obs); end
        repeat (3) step();
        rst_n = 1'b1; base = cyc; mrate = 2'd0; inc = inc_of(2'd0); sw_pend = 0;
        for (int i = 0; i < 4000 && lock_cyc < 0; i++) begin
            step(); checks++;
            if (obs !== exp_v) begin
                errors++; if (errors < 20) $display("FAIL midop_model cyc=%0d: got %b want %b", cyc, obs, exp_v);
            end
            if (obs[6]) lock_cyc = cyc;
        end
        checks++;
        if (lock_cyc - base != ceil_at(LOCK * FRAME_TICKS, inc) + 1) begin
            errors++; $display("FAIL midop_lock: got %0d want %0d", lock_cyc - base, ceil_at(LOCK * FRAME_TICKS, inc) + 1);
        end
    endtask

    task automatic test_random();
        logic [1:0] r;
        int hold;
        for (int k = 0; k < 6; k++) begin
            r    = 2'($urandom_range(0, 3));
            hold = int'($urandom_range(60, 1200));
            set_rate(r);
            repeat (hold) begin
                step(); checks++;
                if (obs !== exp_v) begin
                    errors++; if (errors < 20) $display("FAIL random_model cyc=%0d: got %b want %b", cyc, obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_alignment();
        checks++;
        if (align_bad != 0) begin
            errors++; $display("FAIL alignment: got %0d level changes off mclk_fall want 0", align_bad);
        end
    endtask

    initial begin
        bus.rate_sel = 2'd0;
        test_reset();
        test_rate(2'd1);
        test_rate(2'd2);
        test_rate(2'd3);
        test_rate(2'd0);
        test_midframe();
        test_restart_in_restart();
        test_relock_change();
        test_reset_midop();
        test_random();
        test_alignment();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
